flt_to_int_seq: RTL and testbench

//  Multi-cycle IEEE-754 single-precision -> sign-magnitude integer converter; inverse of the
//  int->float entry path. Feeds float mult/div results back to the integer result bus.

---
 rtl/fi_pkg.sv | 16 +
 rtl/flt_classify.sv | 47 ++++
 rtl/flt_to_int_seq.sv | 145 ++++++++++++++
 tb/tb_flt_to_int_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fi_pkg.sv
// Shared types and IEEE-754 single-precision constants for the float-to-integer converter.
package fi_pkg;

    typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, DONE} state_t;

    typedef enum logic [2:0] {ZERO, NAN, INF, TINY, HUGE, NORMAL} cls_t;

    localparam int         FLT_BIAS    = 127;
    localparam int         FLT_FRAC_W  = 23;
    localparam int         FLT_EXP_W   = 8;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    // |E - 23| never exceeds 150, so 8 bits hold every shift count.
    localparam int         CNT_W       = 8;

endpackage

// File: rtl/flt_classify.sv
// Combinational decode of a single-precision float: value class, unbiased exponent,
// significand with hidden bit, and the shift direction/count that aligns it to an integer.
module flt_classify
    import fi_pkg::*;
#(
    parameter int INT_W = 128
) (
    input  logic [31:0]             flt_in,
    output cls_t                    cls,
    output logic signed [8:0]       exp_unb,
    output logic [INT_W-1:0]        sig,
    output logic                    dir_left,
    output logic [CNT_W-1:0]        cnt
);

    logic [FLT_EXP_W-1:0]  exp_field;
    logic [FLT_FRAC_W-1:0] frac;
    logic signed [8:0]     diff;
    logic signed [8:0]     neg_diff;

    always_comb begin
        exp_field = flt_in[30:23];
        frac      = flt_in[22:0];
        exp_unb   = $signed({1'b0, exp_field}) - 9'sd127;

        sig        = '0;
        sig[23:0]  = {1'b1, frac};

        // Binary point sits 23 bits above the LSB of sig.
        diff     = exp_unb - 9'sd23;
        neg_diff = 9'sd23 - exp_unb;
        dir_left = (exp_unb >= 9'sd23);
        cnt      = dir_left ? diff[CNT_W-1:0] : neg_diff[CNT_W-1:0];

        if (exp_field == '0)
            cls = ZERO;
        else if (exp_field == EXP_SPECIAL)
            cls = (frac != '0) ? NAN : INF;
        else if (exp_unb < 9'sd0)
            cls = TINY;
        else if (int'(exp_unb) >= INT_W)
            cls = HUGE;
        else
            cls = NORMAL;
    end

endmodule

// File: rtl/flt_to_int_seq.sv
// Multi-cycle float -> sign-magnitude integer converter with valid/ready on both sides;
// alignment uses an iterative shifter moving up to SHIFT_STEP bits per cycle.
module flt_to_int_seq
    import fi_pkg::*;
#(
    parameter int INT_W      = 128,
    parameter int SHIFT_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      flt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] int_out,
    output logic             out_sign,
    output logic             ovf,
    output logic             nan
);

    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(SHIFT_STEP);

    state_t            state_q, state_d;
    logic [31:0]       flt_q, flt_d;
    logic [INT_W-1:0]  mag_q, mag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              sign_q, sign_d;
    logic              ovf_q, ovf_d;
    logic              nan_q, nan_d;
    logic              out_valid_q, out_valid_d;

    cls_t              cls;
    logic signed [8:0] exp_unb;
    logic [INT_W-1:0]  sig;
    logic              dir_left;
    logic [CNT_W-1:0]  cls_cnt;
    logic [CNT_W-1:0]  step;

    flt_classify #(.INT_W(INT_W)) u_classify (
        .flt_in   (flt_q),
        .cls      (cls),
        .exp_unb  (exp_unb),
        .sig      (sig),
        .dir_left (dir_left),
        .cnt      (cls_cnt)
    );

    assign step = (cnt_q > STEP_MAX) ? STEP_MAX : cnt_q;

    always_comb begin
        state_d     = state_q;
        flt_d       = flt_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        nan_d       = nan_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    flt_d   = flt_in;
                    state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                sign_d  = 1'b0;
                ovf_d   = 1'b0;
                nan_d   = 1'b0;
                state_d = DONE;
                case (cls)
                    NAN: begin
                        mag_d = '1;
                        nan_d = 1'b1;
                    end
                    INF, HUGE: begin
                        mag_d  = '1;
                        ovf_d  = 1'b1;
                        sign_d = flt_q[31];
                    end
                    NORMAL: begin
                        // E >= 0 here, so the magnitude is at least 1 and the sign is meaningful.
                        mag_d  = sig;
                        dir_d  = dir_left;
                        cnt_d  = cls_cnt;
                        sign_d = flt_q[31];
                        if (cls_cnt != '0)
                            state_d = SHIFT;
                    end
                    default: mag_d = '0;
                endcase
            end
            SHIFT: begin
                mag_d = dir_q ? (mag_q << step) : (mag_q >> step);
                cnt_d = cnt_q - step;
                if (cnt_q == step)
                    state_d = DONE;
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE and holds until accepted.
                if (out_valid_q && out_ready)
                    state_d = IDLE;
                else
                    out_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flt_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flt_q       <= flt_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign int_out   = mag_q;
    assign out_sign  = sign_q;
    assign ovf       = ovf_q;
    assign nan       = nan_q;

endmodule

// File: tb/tb_flt_to_int_seq.sv
// Directed-vector bench for flt_to_int_seq: table of floats with hand-computed results and
// latencies, plus back-pressure and mid-operation reset sequences.
module tb_flt_to_int_seq;

    localparam int INT_W = 128;
    localparam int MAX_WAIT = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      flt_in;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] int_out;
    logic             out_sign;
    logic             ovf;
    logic             nan;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]      flt;
        logic [INT_W-1:0] mag;
        logic             sign;
        logic             ovf;
        logic             nan;
        int               lat;
    } vec_t;

    vec_t vecs[$];

    flt_to_int_seq #(.INT_W(INT_W), .SHIFT_STEP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flt_in    (flt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .int_out   (int_out),
        .out_sign  (out_sign),
        .ovf       (ovf),
        .nan       (nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [INT_W-1:0] act, input logic [INT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] f, input logic [INT_W-1:0] m, input logic s,
                       input logic o, input logic n, input int l);
        vec_t v;
        v.flt = f; v.mag = m; v.sign = s; v.ovf = o; v.nan = n; v.lat = l;
        vecs.push_back(v);
    endtask

    // Called at #1 after a rising edge; leaves the bench at #1 after a rising edge.
    task automatic run_vec(input vec_t v, input bit release_out);
        int lat;
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        flt_in   = v.flt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flt_in   = '0;
        lat = 0;
        while (lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            errors++; checks++;
            $display("FAIL timeout flt=%h: out_valid not seen within %0d cycles", v.flt, MAX_WAIT);
            return;
        end
        $display("txn flt=%h int_out=%h sign=%0d ovf=%0d nan=%0d latency=%0d",
                 v.flt, int_out, out_sign, ovf, nan, lat);
        chk("latency", lat, v.lat);
        chk("int_out", int_out, v.mag);
        chk("out_sign", out_sign, v.sign);
        chk("ovf", ovf, v.ovf);
        chk("nan", nan, v.nan);
        if (release_out) begin
            @(posedge clk); #1;
            chk("out_valid_drop", out_valid, 0);
            chk("in_ready_return", in_ready, 1);
        end
    endtask

    initial begin
        vec_t v3;
        bit   seen;

        add(32'h3F800000, 128'd1,                 0, 0, 0, 5);   // 1.0
        add(32'hC0B80000, 128'd5,                 1, 0, 0, 5);   // -5.75
        add(32'h3F000000, 128'd0,                 0, 0, 0, 2);   // 0.5
        add(32'hBF000000, 128'd0,                 0, 0, 0, 2);   // -0.5
        add(32'h80000000, 128'd0,                 0, 0, 0, 2);   // -0.0
        add(32'h00000001, 128'd0,                 0, 0, 0, 2);   // denormal
        add(32'h40400000, 128'd3,                 0, 0, 0, 5);   // 3.0
        add(32'h4B000000, 128'd8388608,           0, 0, 0, 2);   // 2^23, no shift
        add(32'h4F000000, 128'd1 << 31,           0, 0, 0, 3);   // 2^31, one full step
        add(32'h7F000000, 128'd1 << 127,          0, 0, 0, 15);  // 2^127
        add(32'h71800000, 128'd1 << 100,          0, 0, 0, 12);  // 2^100
        add(32'hF1800000, 128'd1 << 100,          1, 0, 0, 12);  // -2^100
        add(32'h7F7FFFFF, 128'hFFFFFF00_00000000_00000000_00000000, 0, 0, 0, 15);
        add(32'h7F800000, {INT_W{1'b1}},          0, 1, 0, 2);   // +inf
        add(32'hFF800000, {INT_W{1'b1}},          1, 1, 0, 2);   // -inf
        add(32'h7FC00000, {INT_W{1'b1}},          0, 0, 1, 2);   // NaN
        add(32'hFFC00000, {INT_W{1'b1}},          0, 0, 1, 2);   // negative NaN

        rst_n = 1'b0; in_valid = 1'b0; flt_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_int_out", int_out, 0);
        chk("reset_sign", out_sign, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_nan", nan, 0);

        foreach (vecs[i]) run_vec(vecs[i], 1'b1);

        // Back-pressure: result held in DONE, new input ignored.
        out_ready = 1'b0;
        run_vec(vecs[0], 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            flt_in   = 32'h40400000;
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_int_out", int_out, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        flt_in    = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        $display("txn back-pressure sequence complete");
        v3.flt = 32'hC0B80000; v3.mag = 128'd5; v3.sign = 1; v3.ovf = 0; v3.nan = 0; v3.lat = 5;
        run_vec(v3, 1'b1);

        // Reset while shifting 2^127.
        in_valid = 1'b1;
        flt_in   = 32'h7F000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flt_in   = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_int_out", int_out, 0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_pulse", seen, 0);
        $display("txn mid-operation reset sequence complete");
        run_vec(vecs[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
